// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and baud divisor helper.
// Used by both the transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Truncating division: the line runs slightly fast rather than slow.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..ClksPerBit-1 while enabled, pulses tick_o on the last count.
// Clear restarts the period so a new frame never inherits phase from the previous one.
module uart_baud_tick #(
    parameter int unsigned ClksPerBit = 434
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned CntW = (ClksPerBit >= 2) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = enable_i && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Bytes arrive over valid/ready; all line and handshake outputs are registered.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       CLK50M,
    input  logic       RST_N,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TX,
    output logic       tx_busy
);

    localparam int unsigned Cpb = clks_per_bit(CLK_FREQ, BAUD);

    if (PARITY > PAR_ODD) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (Cpb < 2) begin : g_bad_baud
        $error("uart_tx_frame: CLK_FREQ/BAUD must be at least 2");
    end

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        accept;
    logic        tick;

    assign accept = tx_valid && ready_q;

    uart_baud_tick #(
        .ClksPerBit(Cpb)
    ) u_baud (
        .clk_i   (CLK50M),
        .rst_ni  (RST_N),
        .clear_i (accept),
        .enable_i(busy_q),
        .tick_o  (tick)
    );

    // State and datapath registers.
    always_ff @(posedge CLK50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    // Next state; bit_idx doubles as the stop-bit counter.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        par_d     = par_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_START;
                    shift_d   = tx_data;
                    bit_idx_d = '0;
                    par_d     = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
                end
            end
            ST_START: begin
                if (tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            ST_PARITY: begin
                if (tick) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they register on the same edge as the state.
    always_comb begin
        tx_d    = 1'b1;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        unique case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    assign TX       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations driven in parallel, each checked every cycle
// against a frame-timing reference model, plus frame decoding of table vectors and corner cases.
module tb_uart_tx_frame;

    localparam int unsigned ClkFreq = 1_000_000;
    localparam int unsigned Baud    = 250_000;
    localparam int unsigned Cpb     = 4;
    localparam int unsigned NInst   = 4;
    localparam int unsigned CapLen  = 60;

    // Instance configs: 0 none/1 stop, 1 even/1, 2 odd/1, 3 even/2 stop.
    int unsigned par_cfg [NInst] = '{0, 1, 2, 1};
    int unsigned stp_cfg [NInst] = '{1, 1, 1, 2};

    logic             clk     = 1'b0;
    logic             clk_run = 1'b0;
    logic             rst_n   = 1'b1;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic [NInst-1:0] tx_line, rdy, bsy;

    for (genvar g = 0; g < NInst; g++) begin : g_dut
        localparam int unsigned P = (g == 1) ? 1 : ((g == 2) ? 2 : ((g == 3) ? 1 : 0));
        localparam int unsigned S = (g == 3) ? 2 : 1;
        uart_tx_frame #(
            .CLK_FREQ (ClkFreq),
            .BAUD     (Baud),
            .PARITY   (P),
            .STOP_BITS(S)
        ) u_dut (
            .CLK50M  (clk),
            .RST_N   (rst_n),
            .tx_data (tx_data),
            .tx_valid(tx_valid),
            .tx_ready(rdy[g]),
            .TX      (tx_line[g]),
            .tx_busy (bsy[g])
        );
    end

    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int unsigned frame_len(input int i);
        return (1 + 8 + ((par_cfg[i] != 0) ? 1 : 0) + stp_cfg[i]) * Cpb;
    endfunction

    // Line level el cycles after the accept edge, from the frame layout.
    function automatic logic exp_bit(input int i, input logic [7:0] b, input int unsigned el);
        int unsigned k;
        k = el / Cpb;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && par_cfg[i] != 0) return (par_cfg[i] == 1) ? ^b : ~^b;
        return 1'b1;
    endfunction

    // Reference model: per instance, busy flag, cycles since accept, captured byte.
    logic        m_busy [NInst];
    int unsigned m_el   [NInst];
    logic [7:0]  m_byte [NInst];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NInst; i++) begin
            if (!rst_n) begin
                m_busy[i] <= 1'b0;
                m_el[i]   <= 0;
                m_byte[i] <= 8'h00;
            end else if (m_busy[i]) begin
                if (m_el[i] + 1 == frame_len(i)) m_busy[i] <= 1'b0;
                m_el[i] <= m_el[i] + 1;
            end else if (tx_valid) begin
                m_busy[i] <= 1'b1;
                m_el[i]   <= 0;
                m_byte[i] <= tx_data;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance one cycle and compare every instance against the model.
    task automatic tick();
        logic e_tx;
        @(negedge clk);
        for (int i = 0; i < NInst; i++) begin
            e_tx = m_busy[i] ? exp_bit(i, m_byte[i], m_el[i]) : 1'b1;
            chk($sformatf("model_tx[%0d]", i), 32'(tx_line[i]), 32'(e_tx));
            chk($sformatf("model_ready[%0d]", i), 32'(rdy[i]), 32'(!m_busy[i]));
            chk($sformatf("model_busy[%0d]", i), 32'(bsy[i]), 32'(m_busy[i]));
        end
    endtask

    task automatic wait_all_idle();
        int n = 0;
        while (!(&rdy) && n < 200) begin
            tick();
            n++;
        end
        chk("idle_wait", 32'(&rdy), 32'd1);
    endtask

    logic cap_tx  [NInst][CapLen];
    logic cap_rdy [NInst][CapLen];

    // Send one byte to all instances, capture CapLen cycles and decode every frame.
    task automatic frame_check(input logic [7:0] d, input logic exp_even, input bit disturb);
        logic [7:0]  got;
        int          first;
        int unsigned ks, len;
        wait_all_idle();
        tx_data  = d;
        tx_valid = 1'b1;
        for (int c = 0; c < CapLen; c++) begin
            tick();
            tx_valid = 1'b0;
            if (disturb && c == 10) begin
                tx_data  = ~d;
                tx_valid = 1'b1;
            end
            if (disturb && c == 14) tx_data = 8'hAA;
            for (int i = 0; i < NInst; i++) begin
                cap_tx[i][c]  = tx_line[i];
                cap_rdy[i][c] = rdy[i];
            end
        end
        for (int i = 0; i < NInst; i++) begin
            chk($sformatf("start[%0d] %02h", i, d), 32'(cap_tx[i][2]), 32'd0);
            for (int j = 0; j < 8; j++) got[j] = cap_tx[i][(j + 1) * Cpb + 2];
            chk($sformatf("data[%0d] %02h", i, d), 32'(got), 32'(d));
            if (par_cfg[i] != 0)
                chk($sformatf("parity[%0d] %02h", i, d), 32'(cap_tx[i][9 * Cpb + 2]),
                    32'((par_cfg[i] == 1) ? exp_even : !exp_even));
            ks = 9 + ((par_cfg[i] != 0) ? 1 : 0);
            chk($sformatf("stop_first[%0d]", i), 32'(cap_tx[i][ks * Cpb]), 32'd1);
            chk($sformatf("stop_last[%0d]", i), 32'(cap_tx[i][(ks + stp_cfg[i]) * Cpb - 1]),
                32'd1);
            first = -1;
            for (int c = CapLen - 1; c >= 0; c--) if (cap_rdy[i][c]) first = c;
            len = frame_len(i);
            chk($sformatf("frame_len[%0d] %02h", i, d), 32'(first), 32'(len));
        end
    endtask

    typedef struct packed {
        logic [7:0] data;
        logic       exp_even;
    } vec_t;

    vec_t vecs [12];
    logic b2b_tx [CapLen * 2];
    logic [7:0] got_b;

    initial begin
        vecs[0]  = '{data: 8'h55, exp_even: 1'b0};
        vecs[1]  = '{data: 8'h07, exp_even: 1'b1};
        vecs[2]  = '{data: 8'hA5, exp_even: 1'b0};
        vecs[3]  = '{data: 8'h3C, exp_even: 1'b0};
        vecs[4]  = '{data: 8'h01, exp_even: 1'b1};
        vecs[5]  = '{data: 8'hFE, exp_even: 1'b1};
        vecs[6]  = '{data: 8'h00, exp_even: 1'b0};
        vecs[7]  = '{data: 8'hFF, exp_even: 1'b0};
        vecs[8]  = '{data: 8'h80, exp_even: 1'b1};
        vecs[9]  = '{data: 8'h6D, exp_even: 1'b1};
        vecs[10] = '{data: 8'hC3, exp_even: 1'b0};
        vecs[11] = '{data: 8'h0F, exp_even: 1'b0};

        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Asynchronous reset with the clock stopped.
        #1 rst_n = 1'b0;
        #1;
        chk("reset_tx", 32'(tx_line), 32'hF);
        chk("reset_ready", 32'(rdy), 32'hF);
        chk("reset_busy", 32'(bsy), 32'h0);
        #5 rst_n = 1'b1;
        #1;
        chk("post_reset_tx", 32'(tx_line), 32'hF);
        chk("post_reset_busy", 32'(bsy), 32'h0);
        clk_run = 1'b1;
        tick();

        for (int v = 0; v < 12; v++) frame_check(vecs[v].data, vecs[v].exp_even, 1'b0);

        // Back-to-back with tx_valid held: 0xA5 then 0x3C, watched on instance 0.
        wait_all_idle();
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        for (int c = 0; c < CapLen * 2; c++) begin
            tick();
            if (c == 0) tx_data = 8'h3C;
            if (c == 54) tx_valid = 1'b0;
            b2b_tx[c] = tx_line[0];
        end
        for (int j = 0; j < 8; j++) got_b[j] = b2b_tx[(j + 1) * Cpb + 2];
        chk("b2b_first", 32'(got_b), 32'hA5);
        for (int c = 36; c <= 40; c++) chk($sformatf("b2b_gap_%0d", c), 32'(b2b_tx[c]), 32'd1);
        chk("b2b_second_start", 32'(b2b_tx[41]), 32'd0);
        chk("b2b_second_start_end", 32'(b2b_tx[44]), 32'd0);
        for (int j = 0; j < 8; j++) got_b[j] = b2b_tx[41 + (j + 1) * Cpb + 2];
        chk("b2b_second", 32'(got_b), 32'h3C);

        // Input changes and a valid pulse while busy must not disturb the frame.
        frame_check(8'h0F, 1'b0, 1'b1);
        for (int c = 0; c < 12; c++) tick();
        chk("no_second_frame", 32'(bsy), 32'h0);

        // Reset in the middle of data bit 3, then a clean frame.
        wait_all_idle();
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        for (int c = 0; c < 18; c++) begin
            tick();
            tx_valid = 1'b0;
        end
        chk("pre_abort_busy", 32'(bsy), 32'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx", 32'(tx_line), 32'hF);
        chk("abort_ready", 32'(rdy), 32'hF);
        chk("abort_busy", 32'(bsy), 32'h0);
        tick();
        rst_n = 1'b1;
        frame_check(8'hC3, 1'b0, 1'b0);

        // Random traffic checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            tx_data  = 8'($urandom);
            tx_valid = ($urandom_range(0, 7) == 0);
            tick();
        end
        tx_valid = 1'b0;
        wait_all_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
